game_countdown_timer: RTL and testbench

- Consumer end of the 1 ms tick interface.
- Counts one-cycle `tick_1ms` pulses from the 1 ms timer into seconds and counts down a per-question time limit for the mental-math game.
- Drives the `enable` input of the 1 ms timer.
- Reports seconds remaining, a per-second strobe and a time-out event to the game controller FSM.

---
 rtl/game_countdown_timer_pkg.sv | 14 +
 rtl/game_countdown_timer_ms_prescaler.sv | 38 +++
 rtl/game_countdown_timer.sv | 93 +++++++++
 tb/tb_game_countdown_timer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_countdown_timer_pkg.sv
// Shared definitions for the mental-math game timing blocks: countdown state
// encoding and default sizing shared with the score block.
package game_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned MS_PER_SEC_DEFAULT = 1000;
    localparam int unsigned SEC_WIDTH_DEFAULT  = 7;

endpackage

// File: rtl/game_countdown_timer_ms_prescaler.sv
// Modulo-MS_PER_SEC counter of 1 ms ticks; wrap flags the tick that
// completes a second so the seconds counter can step in the same cycle.
module ms_prescaler
    import game_countdown_timer_pkg::*;
#(
    parameter int unsigned MS_PER_SEC = MS_PER_SEC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic advance,
    output logic wrap
);

    localparam int unsigned CW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(MS_PER_SEC - 1);

    logic [CW-1:0] ms_cnt;

    assign wrap = advance && (ms_cnt == LAST);

    // Clear wins over advance so an aborted or restarted countdown starts a
    // fresh second regardless of any tick arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_cnt <= '0;
        end else if (clear) begin
            ms_cnt <= '0;
        end else if (advance) begin
            if (ms_cnt == LAST) begin
                ms_cnt <= '0;
            end else begin
                ms_cnt <= ms_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/game_countdown_timer.sv
// Per-question countdown for the mental-math game: turns 1 ms ticks into
// seconds, reports time remaining and signals time-out to the game FSM.
module game_countdown_timer
    import game_countdown_timer_pkg::*;
#(
    parameter int unsigned MS_PER_SEC = MS_PER_SEC_DEFAULT,
    parameter int unsigned SEC_WIDTH  = SEC_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [SEC_WIDTH-1:0] limit_sec,
    input  logic                 tick_1ms,
    output logic                 tick_enable,
    output logic [SEC_WIDTH-1:0] sec_left,
    output logic                 sec_tick,
    output logic                 running,
    output logic                 expired,
    output logic                 timed_out
);

    state_t               state, state_n;
    logic [SEC_WIDTH-1:0] sec_left_n;
    logic                 sec_tick_n;
    logic                 expired_n;
    logic                 clear;
    logic                 advance;
    logic                 wrap;

    // Ticks only count in RUN when no command is pending; start and stop
    // both restart the millisecond phase.
    assign clear   = start || stop;
    assign advance = (state == ST_RUN) && tick_1ms && !start && !stop;

    ms_prescaler #(
        .MS_PER_SEC (MS_PER_SEC)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .advance (advance),
        .wrap    (wrap)
    );

    assign running     = (state == ST_RUN);
    assign tick_enable = (state == ST_RUN);
    assign timed_out   = (state == ST_DONE);

    // Stop has priority everywhere and keeps sec_left so the score block
    // can use the remaining time; start behaves the same from any state.
    always_comb begin
        state_n    = state;
        sec_left_n = sec_left;
        sec_tick_n = 1'b0;
        expired_n  = 1'b0;

        if (stop) begin
            state_n = ST_IDLE;
        end else if (start) begin
            if (limit_sec != '0) begin
                state_n    = ST_RUN;
                sec_left_n = limit_sec;
            end else begin
                state_n    = ST_DONE;
                sec_left_n = '0;
                expired_n  = 1'b1;
            end
        end else if (wrap && (sec_left != '0)) begin
            sec_left_n = sec_left - SEC_WIDTH'(1);
            sec_tick_n = 1'b1;
            if (sec_left == SEC_WIDTH'(1)) begin
                state_n   = ST_DONE;
                expired_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sec_left <= '0;
            sec_tick <= 1'b0;
            expired  <= 1'b0;
        end else begin
            state    <= state_n;
            sec_left <= sec_left_n;
            sec_tick <= sec_tick_n;
            expired  <= expired_n;
        end
    end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Self-checking bench for game_countdown_timer: an elapsed-tick reference
// model checked every cycle, directed scenarios plus randomized traffic.
module tb_game_countdown_timer;

    localparam int MS = 4;
    localparam int SW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [SW-1:0] limit_sec = '0;
    logic          tick_1ms = 1'b0;
    logic          tick_enable;
    logic [SW-1:0] sec_left;
    logic          sec_tick;
    logic          running;
    logic          expired;
    logic          timed_out;

    int checks = 0;
    int failures = 0;
    int sec_tick_seen = 0;
    int expired_seen = 0;

    // Reference model: mode 0=idle 1=run 2=done; time remaining is the limit
    // minus whole seconds of ticks elapsed since the last start.
    int m_mode = 0;
    int m_limit = 0;
    int m_elapsed = 0;
    int m_frozen = 0;
    bit m_st = 1'b0;
    bit m_ex = 1'b0;

    game_countdown_timer #(
        .MS_PER_SEC (MS),
        .SEC_WIDTH  (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .limit_sec   (limit_sec),
        .tick_1ms    (tick_1ms),
        .tick_enable (tick_enable),
        .sec_left    (sec_left),
        .sec_tick    (sec_tick),
        .running     (running),
        .expired     (expired),
        .timed_out   (timed_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_limit = 0; m_elapsed = 0; m_frozen = 0;
            m_st = 1'b0; m_ex = 1'b0;
        end else begin
            m_st = 1'b0;
            m_ex = 1'b0;
            if (stop) begin
                if (m_mode == 1) m_frozen = m_limit - m_elapsed / MS;
                else if (m_mode == 2) m_frozen = 0;
                m_mode = 0;
            end else if (start) begin
                if (limit_sec == 0) begin
                    m_mode = 2; m_ex = 1'b1; m_frozen = 0;
                end else begin
                    m_mode = 1; m_limit = int'(limit_sec); m_elapsed = 0;
                end
            end else if (m_mode == 1 && tick_1ms) begin
                m_elapsed++;
                if (m_elapsed % MS == 0) begin
                    m_st = 1'b1;
                    if (m_elapsed / MS == m_limit) begin
                        m_ex = 1'b1;
                        m_mode = 2;
                    end
                end
            end
        end
    end

    function automatic int expSecLeft();
        if (m_mode == 1) return m_limit - m_elapsed / MS;
        if (m_mode == 2) return 0;
        return m_frozen;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
        end
    endtask

    // Compare process: every output against the model, once per cycle.
    always @(negedge clk) begin
        checkOutput("sec_left", int'(sec_left), expSecLeft());
        checkOutput("running", int'(running), int'(m_mode == 1));
        checkOutput("tick_enable", int'(tick_enable), int'(m_mode == 1));
        checkOutput("timed_out", int'(timed_out), int'(m_mode == 2));
        checkOutput("sec_tick", int'(sec_tick), int'(m_st));
        checkOutput("expired", int'(expired), int'(m_ex));
        if (sec_tick) sec_tick_seen++;
        if (expired) expired_seen++;
    end

    task automatic applyStimulus(input bit s, input bit p, input int lim, input bit t);
        @(negedge clk);
        #1;
        start = s;
        stop = p;
        limit_sec = SW'(lim);
        tick_1ms = t;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
    endtask

    task automatic stepTicks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0);
            applyStimulus(0, 0, 0, 1);
        end
    endtask

    task automatic clearCounts();
        idleCycles(2);
        sec_tick_seen = 0;
        expired_seen = 0;
    endtask

    initial begin
        $display("[TB] start");
        rst = 1'b1;
        idleCycles(2);
        rst = 1'b0;
        idleCycles(1);
        checkOutput("reset_sec_left", int'(sec_left), 0);
        checkOutput("reset_timed_out", int'(timed_out), 0);

        // Full countdown
        clearCounts();
        applyStimulus(1, 0, 3, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("full_tick_enable", int'(tick_enable), 1);
        checkOutput("full_sec_left_start", int'(sec_left), 3);
        stepTicks(12);
        idleCycles(2);
        checkOutput("full_sec_tick_count", sec_tick_seen, 3);
        checkOutput("full_expired_count", expired_seen, 1);
        checkOutput("full_timed_out", int'(timed_out), 1);
        checkOutput("full_sec_left_end", int'(sec_left), 0);

        // Abort
        applyStimulus(0, 1, 0, 0);
        clearCounts();
        applyStimulus(1, 0, 5, 0);
        stepTicks(6);
        applyStimulus(0, 1, 0, 0);
        stepTicks(4);
        idleCycles(2);
        checkOutput("abort_sec_left", int'(sec_left), 4);
        checkOutput("abort_tick_enable", int'(tick_enable), 0);
        checkOutput("abort_expired_count", expired_seen, 0);

        // Zero limit
        clearCounts();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("zero_tick_enable", int'(tick_enable), 0);
        checkOutput("zero_timed_out", int'(timed_out), 1);
        idleCycles(2);
        checkOutput("zero_expired_count", expired_seen, 1);

        // Start from DONE, then restart mid-second from RUN
        applyStimulus(1, 0, 3, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("done_restart_running", int'(running), 1);
        checkOutput("done_restart_sec_left", int'(sec_left), 3);
        stepTicks(5);
        applyStimulus(1, 0, 7, 1);
        stepTicks(3);
        idleCycles(1);
        checkOutput("restart_sec_left", int'(sec_left), 7);

        // start+stop together in RUN
        applyStimulus(1, 1, 9, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("startstop_running", int'(running), 0);

        // Final-second tick coincident with stop
        applyStimulus(1, 0, 2, 0);
        stepTicks(7);
        clearCounts();
        applyStimulus(0, 1, 0, 1);
        idleCycles(2);
        checkOutput("final_stop_sec_left", int'(sec_left), 1);
        checkOutput("final_stop_expired", expired_seen, 0);
        checkOutput("final_stop_sec_tick", sec_tick_seen, 0);

        // Asynchronous reset mid-RUN
        applyStimulus(1, 0, 5, 0);
        stepTicks(2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_sec_left", int'(sec_left), 0);
        checkOutput("async_tick_enable", int'(tick_enable), 0);
        checkOutput("async_running", int'(running), 0);
        idleCycles(1);
        rst = 1'b0;
        stepTicks(8);
        idleCycles(1);
        checkOutput("post_reset_sec_left", int'(sec_left), 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0),
                          int'($urandom_range(0, 5)), ($urandom_range(0, 2) == 0));
        end
        idleCycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
